fp_matmul_seq: RTL and testbench
================================

// Module: fp_matmul_seq
// PURPOSE
//  Sequencer for the combinational fixed-point matrix multiplier (FPMatMul, Q8.8 words).
//  Collects the A (ROW_1 x COL_1) and B (COL_1 x COL_2) operands from a single
//  element-serial valid/ready stream into operand registers and drives them to the
//  multiplier. It then waits a programmable settle time, captures the flattened product
//  and streams C (ROW_1 x COL_2) out element by element. It sits between the attention
//  datapath's element streams and one FPMatMul instance.
// PARAMETERS
//  DATA_WIDTH      16  width of one matrix element (Q8.8)
//  ROW_1           4   rows of A and of C
//  COL_1           4   cols of A = rows of B
//  COL_2           2   cols of B and of C
//  COMPUTE_CYCLES  1   cycles allowed for the multicycle path through FPMatMul; must be >=1
//                      (elaboration error if 0)
// PORTS
//  clk       in   1                          clock, all logic on rising edge
//  rst       in   1                          synchronous reset, active-high
//  in_valid  in   1                          operand element valid
//  in_ready  out  1                          operand element accepted when valid&&ready
//  in_data   in   DATA_WIDTH                 operand element; all of A, then all of B
//  mm_in_1   out  DATA_WIDTH*ROW_1*COL_1     flattened A to FPMatMul in_1
//  mm_in_2   out  DATA_WIDTH*COL_1*COL_2     flattened B to FPMatMul in_2
//  mm_out    in   DATA_WIDTH*ROW_1*COL_2     flattened C from FPMatMul out
//  out_valid out  1                          result element valid
//  out_ready in   1                          result consumer ready
//  out_data  out  DATA_WIDTH                 result element, row-major
//  out_last  out  1                          high with the final element of C
//  busy      out  1                          job in progress
// BEHAVIOUR
//  - Flattening: element (r,c) of an R x C matrix sits at index k=r*C+c, bits [DW*(k+1)-1 : DW*k].
//    Input and output streams are row-major in k.
//  - FSM: LOAD_A -> LOAD_B -> COMPUTE -> DRAIN -> LOAD_A.
//  - Reset: state LOAD_A; load, wait and drain counters 0; operand and result registers 0.
//    out_valid=0, out_last=0, out_data=0, busy=0.
//    Reset mid-job discards the job. No output beat is emitted for it.
//  - in_ready = (state==LOAD_A || state==LOAD_B). in_valid is ignored in COMPUTE/DRAIN.
//  - LOAD_A: each handshake writes A slot cnt, then cnt++. On the handshake with
//    cnt==ROW_1*COL_1-1, cnt goes to 0 and state goes to LOAD_B.
//  - LOAD_B: same scheme into B. On the handshake for slot COL_1*COL_2-1, go to COMPUTE
//    with the wait counter at 0.
//  - Operand registers are written only on handshakes and hold between jobs.
//    mm_in_1/mm_in_2 are driven directly from them.
//  - COMPUTE: the state lasts exactly COMPUTE_CYCLES cycles. On its last cycle edge,
//    mm_out is captured into the result register and state goes to DRAIN with the out
//    counter at 0.
//    Latency: last B handshake at edge t -> out_valid=1 in the cycle after edge
//    t+COMPUTE_CYCLES.
//  - DRAIN: out_valid=1; out_data = result slot ocnt; out_last=(ocnt==ROW_1*COL_2-1).
//    out_ready low: out_data/out_last stay stable and no element is dropped or repeated.
//    On the handshake of the last element: state LOAD_A, out_valid=0 from the next cycle.
//  - Outputs out_valid/out_data/out_last are functions of registered state only
//    (no in/out combinational path).
//  - busy = (state!=LOAD_A) || (cnt!=0).
//  - No arithmetic in this block. Saturation and rounding belong to FPMatMul.
//    Counters are sized $clog2 of the element count (min 1 bit) and never wrap mid-state.
// TESTING
//  1. Defaults. A = identity (16'h0100 on the diagonal, else 0), B[k] = 16'h0100*(k+1),
//     out_ready=1 -> 8 beats 16'h0100..16'h0800, out_last only on the 8th.
//  2. Same job with out_ready pattern 1,0,0,1,0,1... -> same 8 values in order,
//     out_data held during stalls, exactly 8 handshakes.
//  3. Random in_valid bubbles, plus in_valid held high through COMPUTE/DRAIN ->
//     in_ready=0 there, no extra writes, result identical to test 1.
//  4. COMPUTE_CYCLES=3, last B handshake at edge t -> out_valid first high after edge t+3,
//     never earlier.
//  5. rst pulsed after 3 B elements -> next cycle in_ready=1, busy=0, out_valid=0.
//     A fresh 24-element job yields the correct product.
//  6. Two back-to-back jobs (A all 16'h0080, B all 16'h0200, then test 1 data).
//     Job 1 gives 8 x 16'h0400; job 2 matches test 1. A new A load is accepted the
//     cycle after job 1's last handshake.

Source files
------------

// File: rtl/fp_matmul_seq.sv
// ---------------------------------------------------------------------------
// fp_matmul_seq
//   Sequencer around one combinational fixed-point matrix multiplier
//   (FPMatMul, Q8.8). Gathers A (ROW_1 x COL_1) then B (COL_1 x COL_2) from a
//   single element-serial valid/ready stream, presents them flattened to the
//   multiplier, waits COMPUTE_CYCLES for the multicycle path to settle,
//   captures the flattened product and streams C (ROW_1 x COL_2) out
//   row-major. Element k of a flattened matrix sits at [DW*(k+1)-1 : DW*k].
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand element handshake
//   in_data             operand element: all of A, then all of B
//   mm_in_1, mm_in_2    flattened A and B to the multiplier
//   mm_out              flattened C from the multiplier
//   out_valid/out_ready result element handshake
//   out_data, out_last  result element, high-last on the final element of C
//   busy                a job is in progress
// ---------------------------------------------------------------------------
module fp_matmul_seq #(
  parameter int DATA_WIDTH     = 16,
  parameter int ROW_1          = 4,
  parameter int COL_1          = 4,
  parameter int COL_2          = 2,
  parameter int COMPUTE_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic [DATA_WIDTH*ROW_1*COL_1-1:0] mm_in_1,
  output logic [DATA_WIDTH*COL_1*COL_2-1:0] mm_in_2,
  input  logic [DATA_WIDTH*ROW_1*COL_2-1:0] mm_out,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              busy
);

  localparam int NUM_A    = ROW_1 * COL_1;
  localparam int NUM_B    = COL_1 * COL_2;
  localparam int NUM_C    = ROW_1 * COL_2;
  localparam int NUM_LOAD = (NUM_A > NUM_B) ? NUM_A : NUM_B;
  localparam int LOAD_W   = (NUM_LOAD > 1) ? $clog2(NUM_LOAD) : 1;
  localparam int WAIT_W   = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam int OUT_W    = (NUM_C > 1) ? $clog2(NUM_C) : 1;

  localparam logic [LOAD_W-1:0] A_LAST    = LOAD_W'(NUM_A - 1);
  localparam logic [LOAD_W-1:0] B_LAST    = LOAD_W'(NUM_B - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(COMPUTE_CYCLES - 1);
  localparam logic [OUT_W-1:0]  C_LAST    = OUT_W'(NUM_C - 1);

  // A zero settle time would leave no cycle for the multiplier path.
  if (COMPUTE_CYCLES < 1) begin : g_bad_compute_cycles
    $error("fp_matmul_seq: COMPUTE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_t;

  state_t                              state;
  logic [LOAD_W-1:0]                   load_cnt;
  logic [WAIT_W-1:0]                   wait_cnt;
  logic [OUT_W-1:0]                    out_cnt;
  logic [DATA_WIDTH*NUM_A-1:0]         a_reg;
  logic [DATA_WIDTH*NUM_B-1:0]         b_reg;
  logic [DATA_WIDTH*NUM_C-1:0]         c_reg;

  logic in_fire;
  logic out_fire;

  // Every output below decodes registers only, so no combinational path
  // runs from in_valid/out_ready to any output.
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == DRAIN);
  assign out_data  = c_reg[int'(out_cnt)*DATA_WIDTH +: DATA_WIDTH];
  assign out_last  = out_valid && (out_cnt == C_LAST);
  assign busy      = (state != LOAD_A) || (load_cnt != '0);
  assign mm_in_1   = a_reg;
  assign mm_in_2   = b_reg;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      load_cnt <= '0;
      wait_cnt <= '0;
      out_cnt  <= '0;
      // NOTE: the operand/result arrays are plain flops and are cleared so
      // the multiplier inputs and out_data are defined straight after reset.
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
    end else begin
      unique case (state)
        LOAD_A: begin
          if (in_fire) begin
            a_reg[int'(load_cnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (load_cnt == A_LAST) begin
              load_cnt <= '0;
              state    <= LOAD_B;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            b_reg[int'(load_cnt)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            if (load_cnt == B_LAST) begin
              load_cnt <= '0;
              wait_cnt <= '0;
              state    <= COMPUTE;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        COMPUTE: begin
          // Operands have been stable since the last B write; capture the
          // product on the final edge of the settle window.
          if (wait_cnt == WAIT_LAST) begin
            c_reg    <= mm_out;
            wait_cnt <= '0;
            out_cnt  <= '0;
            state    <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_cnt == C_LAST) begin
              out_cnt <= '0;
              state   <= LOAD_A;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_matmul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_matmul_seq
//   Self-checking bench for fp_matmul_seq. A behavioural Q8.8 multiplier
//   drives mm_out. Expected result beats are queued when a job's stimulus is
//   issued and popped as the DUT emits them. A second instance with
//   COMPUTE_CYCLES=3 is used for the latency scenario; sel3 steers the shared
//   stimulus/observation signals to it.
// ---------------------------------------------------------------------------
module tb_fp_matmul_seq;

  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic out_ready;
  logic sel3;

  logic in_valid1, in_ready1, out_valid1, out_last1, busy1;
  logic [DW-1:0] out_data1;
  logic [255:0] mm_in_1_1;
  logic [127:0] mm_in_2_1, mm_out1;

  logic in_valid3, in_ready3, out_valid3, out_last3, busy3;
  logic [DW-1:0] out_data3;
  logic [255:0] mm_in_1_3;
  logic [127:0] mm_in_2_3, mm_out3;

  logic cur_in_ready, obs_valid, obs_last, obs_busy;
  logic [DW-1:0] obs_data;
  logic [255:0] obs_mm1;
  logic [127:0] obs_mm2;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t exp_q[$];
  bit stall_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic [255:0] a_id, a_half;
  logic [127:0] b_seq, b_two, c_seq, c_four;

  always #5 clk = ~clk;

  // Behavioural FPMatMul: signed Q8.8 dot products, result >>> 8.
  function automatic logic [127:0] matmul(input logic [255:0] a, input logic [127:0] b);
    logic [127:0] c;
    int acc;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 2; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += int'($signed(a[(r*4+k)*DW +: DW])) * int'($signed(b[(k*2+j)*DW +: DW]));
        acc = acc >>> 8;
        c[(r*2+j)*DW +: DW] = acc[15:0];
      end
    end
    return c;
  endfunction

  assign mm_out1 = matmul(mm_in_1_1, mm_in_2_1);
  assign mm_out3 = matmul(mm_in_1_3, mm_in_2_3);

  assign in_valid1    = in_valid & ~sel3;
  assign in_valid3    = in_valid & sel3;
  assign cur_in_ready = sel3 ? in_ready3  : in_ready1;
  assign obs_valid    = sel3 ? out_valid3 : out_valid1;
  assign obs_data     = sel3 ? out_data3  : out_data1;
  assign obs_last     = sel3 ? out_last3  : out_last1;
  assign obs_busy     = sel3 ? busy3      : busy1;
  assign obs_mm1      = sel3 ? mm_in_1_3  : mm_in_1_1;
  assign obs_mm2      = sel3 ? mm_in_2_3  : mm_in_2_1;

  fp_matmul_seq #(.COMPUTE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .mm_in_1(mm_in_1_1), .mm_in_2(mm_in_2_1), .mm_out(mm_out1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_last(out_last1), .busy(busy1)
  );

  fp_matmul_seq #(.COMPUTE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .mm_in_1(mm_in_1_3), .mm_in_2(mm_in_2_3), .mm_out(mm_out3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3)
  );

  task automatic push_expect(input logic [127:0] c);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.data = c[k*DW +: DW];
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  // Starts and ends at a falling edge. Sends the first n_el elements of A then B.
  task automatic send_job(input logic [255:0] a, input logic [127:0] b, input int n_el,
                          input int bubble_pct, input bit hold);
    logic [DW-1:0] elem;
    bit acc;
    int guard;
    for (int i = 0; i < n_el; i++) begin
      elem  = (i < 16) ? a[i*DW +: DW] : b[(i-16)*DW +: DW];
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 200) begin
        if (int'($urandom_range(99)) < bubble_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = elem;
        end
        acc = in_valid && cur_in_ready;
        guard++;
        @(posedge clk);
        @(negedge clk);
      end
      if (!acc) begin
        n_cmp++; n_bad++;
        $display("FAIL load_timeout: element %0d not accepted, required in_ready within 200 cycles", i);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = hold;
    in_data  = 16'hDEAD;
  endtask

  // Consumes n result beats against the scoreboard, then checks the idle state.
  task automatic drain(input int n, input int mode, input bit chk_in);
    int hs = 0;
    int step = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    beat_t e;
    while (hs < n && step < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = stall_pat[step % 6];
        default: out_ready = 1'($urandom_range(1));
      endcase
      if (obs_valid) begin
        if (stalled) begin
          n_cmp++;
          if (obs_data !== prev_d || obs_last !== prev_l) begin
            n_bad++;
            $display("FAIL stall_hold: data=%h last=%b, required data=%h last=%b", obs_data, obs_last, prev_d, prev_l);
          end
        end
        if (chk_in) begin
          n_cmp++;
          if (cur_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL in_ready_drain: in_ready=%b, required 0", cur_in_ready);
          end
        end
        if (out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL extra_beat: data=%h, required no beat", obs_data);
          end else begin
            e = exp_q.pop_front();
            if (obs_data !== e.data || obs_last !== e.last) begin
              n_bad++;
              $display("FAIL beat_%0d: data=%h last=%b, required data=%h last=%b", hs, obs_data, obs_last, e.data, e.last);
            end
          end
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev_d  = obs_data;
          prev_l  = obs_last;
        end
      end
      step++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (hs < n) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d beats, required %0d", hs, n);
    end
    n_cmp++;
    if (obs_valid !== 1'b0 || cur_in_ready !== 1'b1 || obs_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_drain: out_valid=%b in_ready=%b busy=%b, required 0 1 0", obs_valid, cur_in_ready, obs_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0 || out_last1 !== 1'b0 || out_data1 !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b out_last=%b out_data=%h, required 1 0 0 0 0000",
               in_ready1, busy1, out_valid1, out_last1, out_data1);
    end
    n_cmp++;
    if (mm_in_1_1 !== '0 || mm_in_2_1 !== '0 || out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_regs: mm_in_1=%h mm_in_2=%h v3=%b r3=%b, required zero operands, v3=0 r3=1",
               mm_in_1_1, mm_in_2_1, out_valid3, in_ready3);
    end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    send_job(a_id, b_seq, 24, 0, 1'b0);
    push_expect(c_seq);
    n_cmp++;
    if (busy1 !== 1'b1 || in_ready1 !== 1'b0) begin
      n_bad++;
      $display("FAIL compute_state: busy=%b in_ready=%b, required 1 0", busy1, in_ready1);
    end
    drain(8, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    send_job(a_id, b_seq, 24, 0, 1'b0);
    push_expect(c_seq);
    drain(8, 1, 1'b0);
  endtask

  task automatic test_bubbles();
    send_job(a_id, b_seq, 24, 40, 1'b1);
    push_expect(c_seq);
    n_cmp++;
    if (in_ready1 !== 1'b0) begin
      n_bad++;
      $display("FAIL in_ready_compute: in_ready=%b, required 0", in_ready1);
    end
    drain(8, 0, 1'b1);
    n_cmp++;
    if (mm_in_1_1 !== a_id || mm_in_2_1 !== b_seq) begin
      n_bad++;
      $display("FAIL operand_hold: mm_in_1=%h mm_in_2=%h, required %h %h", mm_in_1_1, mm_in_2_1, a_id, b_seq);
    end
  endtask

  task automatic test_latency();
    sel3 = 1'b1;
    send_job(a_id, b_seq, 24, 0, 1'b0);
    push_expect(c_seq);
    // Now in the cycle after edge t (last B handshake).
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid3 !== (k == 3)) begin
        n_bad++;
        $display("FAIL latency_t+%0d: out_valid=%b, required %b", k, out_valid3, (k == 3));
      end
      if (k < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    drain(8, 0, 1'b0);
    sel3 = 1'b0;
  endtask

  task automatic test_mid_reset();
    send_job(a_half, b_two, 19, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready1, busy1, out_valid1);
    end
    send_job(a_id, b_seq, 24, 20, 1'b0);
    push_expect(c_seq);
    drain(8, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    send_job(a_half, b_two, 24, 0, 1'b0);
    push_expect(c_four);
    drain(8, 0, 1'b0);
    // drain ended in the cycle after job 1's last handshake with in_ready=1;
    // the first A element is offered in this same cycle.
    n_cmp++;
    if (in_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: in_ready=%b, required 1", in_ready1);
    end
    send_job(a_id, b_seq, 24, 0, 1'b0);
    push_expect(c_seq);
    drain(8, 0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: %0d beats pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    sel3      = 1'b0;
    a_id      = '0;
    a_half    = '0;
    for (int r = 0; r < 4; r++) begin
      a_id[(r*4+r)*DW +: DW] = 16'h0100;
      for (int k = 0; k < 4; k++) a_half[(r*4+k)*DW +: DW] = 16'h0080;
    end
    for (int k = 0; k < 8; k++) begin
      b_seq[k*DW +: DW]  = 16'((k + 1) * 16'h0100);
      b_two[k*DW +: DW]  = 16'h0200;
      c_seq[k*DW +: DW]  = 16'((k + 1) * 16'h0100);
      c_four[k*DW +: DW] = 16'h0400;
    end
    @(negedge clk);
    test_reset();
    test_identity();
    test_backpressure();
    test_bubbles();
    test_latency();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
